// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs232_pkg
// Purpose  : Shared defaults, frame constants and FSM state types for the
//            rs232_plus UART echo path.
// Revision : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  localparam int DEFAULT_CLK_FREQ     = 50_000_000;
  localparam int DEFAULT_BAUD         = 9600;
  localparam int DEFAULT_BAUD_CNT_MAX = DEFAULT_CLK_FREQ / DEFAULT_BAUD;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/rs232_rx.sv
`default_nettype none
// ============================================================================
// Module   : rs232_rx
// Purpose  : 8N1 receiver. Three-flop synchronizer with falling-edge start
//            detect, mid-bit sampling, false-start and framing-error reject.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int BAUD_CNT_MAX = DEFAULT_BAUD_CNT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);

  localparam int              CNT_W    = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2);
  localparam logic [3:0]       BIT_STOP = 4'(FRAME_BITS - 1);

  logic [2:0]       sync_q;
  rx_state_t        state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             valid_q;

  logic w_bit;
  logic w_fall;

  // sync_q[1] is the metastability-safe line value, sync_q[2] its previous value
  assign w_bit  = sync_q[1];
  assign w_fall = sync_q[2] & ~sync_q[1];

  // Synchronizer; resets to idle-high so a line held low through reset reads as a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
    end
  end

  // Receive FSM: start detect, per-bit baud counting, mid-bit sampling, frame validation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (w_fall) begin
            state_q    <= RX_RECV;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
          end
        end

        RX_RECV: begin
          if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= bit_cnt_q + 4'd1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end

          if (baud_cnt_q == CNT_MID) begin
            if (bit_cnt_q == 4'd0) begin
              // Line back high mid start bit: glitch, not a frame
              if (w_bit) begin
                state_q    <= RX_IDLE;
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else if (bit_cnt_q == BIT_STOP) begin
              // Leave mid stop bit so the next start edge is never missed
              baud_cnt_q <= '0;
              bit_cnt_q  <= '0;
              if (w_bit) begin
                state_q <= RX_DONE;
                valid_q <= 1'b1;
              end else begin
                state_q <= RX_IDLE;
              end
            end else begin
              shift_q <= {w_bit, shift_q[7:1]};
            end
          end
        end

        RX_DONE: begin
          state_q <= RX_IDLE;
        end

        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data_o  = shift_q;
  assign rx_valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/rs232_tx.sv
`default_nettype none
// ============================================================================
// Module   : rs232_tx
// Purpose  : 8N1 transmitter with registered serial output. Starts a frame
//            on tx_start_i when idle; requests while busy are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int BAUD_CNT_MAX = DEFAULT_BAUD_CNT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam int              CNT_W    = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [3:0]       BIT_STOP = 4'(FRAME_BITS - 1);

  tx_state_t        state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [8:0]       shift_q;   // {stop, d7..d0}, shifted out LSB first after the start bit
  logic             tx_q;

  // Transmit FSM: start bit goes out on the edge that accepts the byte, each bit held one baud period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TX_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (tx_start_i) begin
            state_q    <= TX_SEND;
            shift_q    <= {1'b1, tx_data_i};
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b0;
          end
        end

        TX_SEND: begin
          if (baud_cnt_q == CNT_LAST) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == BIT_STOP) begin
              state_q   <= TX_IDLE;
              bit_cnt_q <= '0;
              tx_q      <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[8:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= TX_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q == TX_SEND);

endmodule
`default_nettype wire

// File: rtl/rs232_plus.sv
`default_nettype none
// ============================================================================
// Module   : rs232_plus
// Purpose  : UART echo path: every byte received on rx is retransmitted
//            unchanged on tx.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_plus
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int BAUD_CNT_MAX = CLK_FREQ / BAUD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);

  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic       w_tx_busy;
  logic       w_tx_start;

  // A byte completing while the transmitter is still busy is dropped
  assign w_tx_start = w_rx_valid & ~w_tx_busy;

  rs232_rx #(
    .BAUD_CNT_MAX (BAUD_CNT_MAX)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx),
    .rx_data_o  (w_rx_data),
    .rx_valid_o (w_rx_valid)
  );

  rs232_tx #(
    .BAUD_CNT_MAX (BAUD_CNT_MAX)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data_i  (w_rx_data),
    .tx_start_i (w_tx_start),
    .tx_o       (tx),
    .tx_busy_o  (w_tx_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_rs232_plus.sv
// ============================================================================
// Module   : tb_rs232_plus
// Purpose  : Scoreboard bench for the rs232_plus echo path at a reduced
//            bit period (16 clocks per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs232_plus;

  localparam int B = 16;  // clocks per bit with the parameters below

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  rs232_plus #(
    .CLK_FREQ     (160_000),
    .BAUD         (10_000),
    .BAUD_CNT_MAX (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  int          frames_done = 0;
  bit          mon_busy    = 1'b0;
  bit          abort_ok    = 1'b0;
  int          pass_cnt    = 0;
  int          total_cnt   = 0;
  int unsigned rx_fall_cyc = 0;
  int unsigned tx_fall_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: decode every frame seen on tx and compare against the scoreboard
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       first;
    int         glitches;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        mon_busy    = 1'b1;
        tx_fall_cyc = cyc;
        bits        = '0;
        glitches    = 0;
        aborted     = 1'b0;
        first       = 1'b0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          for (int j = 0; j < B && !aborted; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
            end else begin
              if (j == 0) first = tx;
              else if (tx !== first) glitches++;
              if (j == B / 2) bits[i] = tx;
            end
          end
        end
        if (aborted) begin
          check("frame cut by reset only when reset was applied", abort_ok, 1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          check("frame on tx was expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("echo byte", bits[8:1], exp_b);
          end
          check("start bit", bits[0], 0);
          check("stop bit", bits[9], 1);
          check("bit held full period", glitches, 0);
          frames_done++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    logic [9:0] f;
    f = {stop_v, d, 1'b0};
    @(posedge clk); #1;
    rx_fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (B) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * B) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard drained in time", (exp_q.size() == 0 && !mon_busy), 1);
  endtask

  logic [7:0] four_bytes [4] = '{8'h3E, 8'hC1, 8'h07, 8'hF0};

  initial begin : stim
    int bad;
    int f0;
    int lat;
    int n;

    // Reset held with rx low: tx must stay idle
    rst_n = 1'b0;
    rx    = 1'b0;
    bad   = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("tx high throughout reset", bad, 0);

    // Release with rx still low: counts as a start edge, frame follows
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1);
    idle_bits(2);
    wait_drain(20 * B);
    check("tx idle after first echo", tx, 1);

    // Single byte with latency measurement
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain(20 * B);
    lat = int'(tx_fall_cyc - rx_fall_cyc);
    if (lat < 9 * B + B / 2 + 2 || lat > 9 * B + B / 2 + 6)
      $display("FAIL echo latency: got %0d clocks, expected %0d..%0d", lat, 9 * B + B / 2 + 2, 9 * B + B / 2 + 6);
    check("echo latency within window", (lat >= 9 * B + B / 2 + 2 && lat <= 9 * B + B / 2 + 6), 1);

    // Four bytes with one idle bit between frames
    f0 = frames_done;
    foreach (four_bytes[k]) begin
      exp_q.push_back(four_bytes[k]);
      send_frame(four_bytes[k], 1'b1);
      idle_bits(1);
    end
    wait_drain(30 * B);
    check("four frames echoed", frames_done - f0, 4);
    check("tx idle after burst", tx, 1);

    // Framing error drops the byte; next good frame still echoes
    f0 = frames_done;
    send_frame(8'h3C, 1'b0);
    idle_bits(2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    wait_drain(30 * B);
    check("only frame after framing error echoed", frames_done - f0, 1);

    // Short glitch on idle line: no transmission
    f0 = frames_done;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (B / 4) @(posedge clk);
    #1;
    idle_bits(20);
    check("no echo for false start", frames_done - f0, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_drain(20 * B);
    check("frame after false start echoed", frames_done - f0, 1);

    // Reset in the middle of an echo
    f0 = frames_done;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    n = 0;
    while (tx !== 1'b0 && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("tx sending before reset", tx, 0);
    abort_ok = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("tx high immediately on reset", tx, 1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(25);
    check("no frame resumed after reset", frames_done - f0, 0);
    check("aborted expectation consumed", exp_q.size(), 0);
    check("tx idle after reset recovery", tx, 1);
    abort_ok = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
